// File: rtl/fpu_pkg.sv
// fpu_pkg: shared fp32 field layout, special constants and exception flag positions
package fpu_pkg;
  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
  localparam int FLG_NV = 2;
  localparam int FLG_OF = 1;
  localparam int FLG_UF = 0;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;
endpackage

// File: rtl/fsub_wb_classify.sv
// fsub_wb_classify: replaces fsub results it cannot produce correctly and derives {NV,OF,UF}
module fsub_wb_classify
  import fpu_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] y,
  output logic [31:0] data,
  output logic [2:0]  flags
);
  fp32_t a, b, r;
  logic a_nan, b_nan, a_inf, b_inf;
  assign a = x1;
  assign b = x2;
  assign r = y;
  assign a_nan = a.exp == FP_EXP_MAX && a.mant != '0;
  assign b_nan = b.exp == FP_EXP_MAX && b.mant != '0;
  assign a_inf = a.exp == FP_EXP_MAX && a.mant == '0;
  assign b_inf = b.exp == FP_EXP_MAX && b.mant == '0;
  // first matching rule wins; x1 == x2 covers equal magnitude with equal sign
  always_comb begin
    data  = y;
    flags = '0;
    if (a_nan || b_nan) begin
      data          = FP_CANON_NAN;
      flags[FLG_NV] = (a_nan && !a.mant[22]) || (b_nan && !b.mant[22]);
    end else if (a_inf && b_inf && a.sign == b.sign) begin
      data          = FP_CANON_NAN;
      flags[FLG_NV] = 1'b1;
    end else if (a_inf) begin
      data = x1;
    end else if (b_inf) begin
      data = {~b.sign, x2[30:0]};
    end else if (x1 == x2) begin
      data = '0;
    end else if (r.exp == FP_EXP_MAX) begin
      data          = {r.sign, FP_EXP_MAX, 23'b0};
      flags[FLG_OF] = 1'b1;
    end else if (r.exp == '0 && y[30:0] != '0) begin
      data          = {r.sign, 31'b0};
      flags[FLG_UF] = 1'b1;
    end
  end
endmodule

// File: rtl/fsub_wb.sv
// fsub_wb: sanitized fsub writeback FIFO; FSUB_WB_STATS_EN adds OF/UF saturating counters
module fsub_wb
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TAGW-1:0] in_tag,
  input  logic [31:0]     in_x1,
  input  logic [31:0]     in_x2,
  input  logic [31:0]     in_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [31:0]     out_data,
  output logic [2:0]      out_flags
`ifdef FSUB_WB_STATS_EN
  ,
  output logic [15:0]     stat_of_cnt,
  output logic [15:0]     stat_uf_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [TAGW-1:0] tag_q [DEPTH];
  logic [31:0]     dat_q [DEPTH];
  logic [2:0]      flg_q [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [31:0]     cls_data;
  logic [2:0]      cls_flags;
  logic            push, pop;
  fsub_wb_classify u_cls (
    .x1    (in_x1),
    .x2    (in_x2),
    .y     (in_y),
    .data  (cls_data),
    .flags (cls_flags)
  );
  assign in_ready  = count != FULL;
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_tag   = tag_q[rptr];
  assign out_data  = dat_q[rptr];
  assign out_flags = flg_q[rptr];
  // storage is cleared too so the head reads as zero straight out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        dat_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      if (push) begin
        tag_q[wptr] <= in_tag;
        dat_q[wptr] <= cls_data;
        flg_q[wptr] <= cls_flags;
        wptr        <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
`ifdef FSUB_WB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_of_cnt <= '0;
      stat_uf_cnt <= '0;
    end else begin
      if (push && cls_flags[FLG_OF] && stat_of_cnt != 16'hFFFF) stat_of_cnt <= stat_of_cnt + 1'b1;
      if (push && cls_flags[FLG_UF] && stat_uf_cnt != 16'hFFFF) stat_uf_cnt <= stat_uf_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fsub_wb.sv
// tb_fsub_wb: directed checks of fsub_wb classification, FIFO order/backpressure and async reset
module tb_fsub_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] in_x1, in_x2, in_y, out_data;
  logic [2:0]  out_flags;
`ifdef FSUB_WB_STATS_EN
  logic [15:0] stat_of_cnt, stat_uf_cnt;
`endif
  int checks = 0;
  int failures = 0;

  fsub_wb #(.DEPTH(4), .TAGW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .out_flags (out_flags)
`ifdef FSUB_WB_STATS_EN
    ,
    .stat_of_cnt (stat_of_cnt),
    .stat_uf_cnt (stat_uf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] t, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_valid = v;
    in_tag   = t;
    in_x1    = a;
    in_x2    = b;
    in_y     = c;
  endtask

  task automatic send(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    drive(1'b1, t, a, b, c);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic head(input string n, input logic [4:0] t, input logic [31:0] d, input logic [2:0] f);
    check({n, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({n, "_tag"},   {27'b0, out_tag}, {27'b0, t});
    check({n, "_data"},  out_data, d);
    check({n, "_flags"}, {29'b0, out_flags}, {29'b0, f});
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", {27'b0, out_tag}, 32'd0);
    check("rst_out_flags", {29'b0, out_flags}, 32'd0);
`ifdef FSUB_WB_STATS_EN
    check("rst_stat_of", {16'b0, stat_of_cnt}, 32'd0);
    check("rst_stat_uf", {16'b0, stat_uf_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // back-to-back sends: each head is checked the cycle after its push while the next one pushes
    send(5'd3, 32'h40400000, 32'h3F800000, 32'h40000000);
    head("normal", 5'd3, 32'h40000000, 3'b000);
    send(5'd4, 32'h7F800000, 32'h7F800000, 32'h12345678);
    head("inf_minus_inf", 5'd4, 32'h7FC00000, 3'b100);
    send(5'd5, 32'h7FA00000, 32'h3F800000, 32'h00000000);
    head("snan", 5'd5, 32'h7FC00000, 3'b100);
    send(5'd6, 32'h3F800000, 32'h7FC00001, 32'h00000000);
    head("qnan", 5'd6, 32'h7FC00000, 3'b000);
    send(5'd7, 32'hBF800000, 32'hBF800000, 32'h12345678);
    head("cancel", 5'd7, 32'h00000000, 3'b000);
    send(5'd8, 32'h3F800000, 32'h3F800001, 32'h00012345);
    head("underflow", 5'd8, 32'h00000000, 3'b001);
    send(5'd9, 32'h3F800001, 32'h3F800000, 32'h80000001);
    head("underflow_neg", 5'd9, 32'h80000000, 3'b001);
    send(5'd10, 32'h3F800001, 32'hBF800001, 32'h80000000);
    head("neg_zero_pass", 5'd10, 32'h80000000, 3'b000);
    send(5'd11, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F812345);
    head("overflow", 5'd11, 32'h7F800000, 3'b010);
    send(5'd12, 32'hFF800000, 32'h3F800000, 32'h00000000);
    head("x1_inf", 5'd12, 32'hFF800000, 3'b000);
    send(5'd13, 32'h3F800000, 32'h7F800000, 32'h00000000);
    head("x2_inf", 5'd13, 32'hFF800000, 3'b000);
    send(5'd14, 32'h7F800000, 32'hFF800000, 32'h00000000);
    head("inf_minus_neginf", 5'd14, 32'h7F800000, 3'b000);
    @(negedge clk);
    check("drained", {31'b0, out_valid}, 32'd0);
`ifdef FSUB_WB_STATS_EN
    check("stat_of", {16'b0, stat_of_cnt}, 32'd1);
    check("stat_uf", {16'b0, stat_uf_cnt}, 32'd2);
`endif
    out_ready = 1'b0;
    for (int t = 1; t <= 4; t++) send(5'(t), 32'h40400000, 32'h3F800000, 32'h40000000 + t);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 5'd5, 32'h40400000, 32'h3F800000, 32'h40000005);
    @(negedge clk);
    check("full_hold_ready", {31'b0, in_ready}, 32'd0);
    head("full_head", 5'd1, 32'h40000001, 3'b000);
    out_ready = 1'b1;
    @(negedge clk);
    check("after_pop_ready", {31'b0, in_ready}, 32'd1);
    head("drain2", 5'd2, 32'h40000002, 3'b000);
    @(negedge clk);
    in_valid = 1'b0;
    head("drain3", 5'd3, 32'h40000003, 3'b000);
    @(negedge clk);
    head("drain4", 5'd4, 32'h40000004, 3'b000);
    @(negedge clk);
    head("drain5", 5'd5, 32'h40000005, 3'b000);
    @(negedge clk);
    check("order_empty", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    for (int t = 20; t < 23; t++) send(5'(t), 32'h40400000, 32'h3F800000, 32'h40000000);
    head("pre_rst", 5'd20, 32'h40000000, 3'b000);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_out_tag", {27'b0, out_tag}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    send(5'd25, 32'h40400000, 32'h3F800000, 32'h40000000);
    head("post_rst", 5'd25, 32'h40000000, 3'b000);
    @(negedge clk);
    check("post_rst_alone", {31'b0, out_valid}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
